// File: rtl/vector_pkg.sv
// Shared types for the vector beam engine: coordinate width, FSM states and command ops.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vector_pkg;

  localparam int DEF_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    SETTLE
  } state_t;

  typedef enum logic {
    OP_JUMP,
    OP_DRAW
  } op_t;

endpackage

// File: rtl/beam_line_engine_if.sv
// Vector command bus: (x, y, draw, jump) command in, ready plus beam position/enable out.
// Latency: n/a (wiring only).
// Backpressure: the command side holds draw/jump until it observes ready=1 on a clock edge.
interface beam_line_engine_if #(
  parameter int WIDTH = vector_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             draw;
  logic             jump;
  logic             ready;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic             beam_on;

  // Command generator / DAC stage side
  modport master (
    output x, y, draw, jump,
    input  ready, x_out, y_out, beam_on
  );

  // Beam engine side
  modport slave (
    input  x, y, draw, jump,
    output ready, x_out, y_out, beam_on
  );
endinterface

// File: rtl/beam_line_engine_line_stepper.sv
// Bresenham line stepper: holds beam position and dx/dy/err/sx/sy, steps one point per strobe.
// Latency: load, step and move each take effect on the next clock edge.
// Backpressure: none; the parent decides when to strobe.
module line_stepper
  import vector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             move,
  input  logic [WIDTH-1:0] tx,
  input  logic [WIDTH-1:0] ty,
  output logic [WIDTH-1:0] x_pos,
  output logic [WIDTH-1:0] y_pos,
  output logic             done
);
  // Two extra bits: one for sign, one so |dx| = 2^WIDTH-1 and err never overflow.
  localparam int EW = WIDTH + 2;

  logic signed [EW-1:0] dx, dy, err;
  logic signed [1:0]    sx, sy;
  logic signed [EW-1:0] ddx, ddy, adx, ady, err_nxt;
  logic signed [1:0]    sx_nxt, sy_nxt;
  logic signed [EW:0]   e2;
  logic                 stx, sty;

  // Signed distance from the current beam position to the target, with magnitude and sign
  always_comb begin
    ddx    = $signed({2'b00, tx}) - $signed({2'b00, x_pos});
    ddy    = $signed({2'b00, ty}) - $signed({2'b00, y_pos});
    adx    = ddx[EW-1] ? -ddx : ddx;
    ady    = ddy[EW-1] ? -ddy : ddy;
    sx_nxt = (ddx == '0) ? 2'sb00 : (ddx[EW-1] ? 2'sb11 : 2'sb01);
    sy_nxt = (ddy == '0) ? 2'sb00 : (ddy[EW-1] ? 2'sb11 : 2'sb01);
  end

  // Bresenham decision: both tests use the error before this step's updates
  always_comb begin
    e2      = {err, 1'b0};
    stx     = (e2 >= dy);
    sty     = (e2 <= dx);
    err_nxt = err;
    if (stx) err_nxt = err_nxt + dy;
    if (sty) err_nxt = err_nxt + dx;
  end

  assign done = (x_pos == tx) && (y_pos == ty);

  // Line state and beam position; move (jump) overrides any step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dx    <= '0;
      dy    <= '0;
      err   <= '0;
      sx    <= '0;
      sy    <= '0;
      x_pos <= '0;
      y_pos <= '0;
    end else begin
      if (load) begin
        dx  <= adx;
        dy  <= -ady;
        err <= adx - ady;
        sx  <= sx_nxt;
        sy  <= sy_nxt;
      end else if (step) begin
        err <= err_nxt;
        if (stx) x_pos <= x_pos + WIDTH'(sx);
        if (sty) y_pos <= y_pos + WIDTH'(sy);
      end
      if (move) begin
        x_pos <= tx;
        y_pos <= ty;
      end
    end
  end
endmodule

// File: rtl/beam_line_engine.sv
// Vector beam engine: blanked jumps and beam-on Bresenham draws to the X/Y DAC; BEAM_JUMP_SETTLE_EN adds post-jump dwell.
// Latency: jump ready at edge 1 (+SETTLE_CYCLES with dwell); draw ready at edge 1+(N+1)*STEP_DIV.
// Backpressure: ready=1 only in IDLE; draw/jump are level-sampled when ready, never queued.
module beam_line_engine
  import vector_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STEP_DIV      = 1,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  beam_line_engine_if.slave   bus
);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

`ifdef BEAM_JUMP_SETTLE_EN
  localparam bit JUMP_DWELL = (SETTLE_CYCLES > 0);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  logic [SW-1:0] settle_cnt;
`else
  // Without the dwell feature the settle length has no effect.
  localparam bit JUMP_DWELL = 1'b0 && (SETTLE_CYCLES > 0);
`endif

  state_t           state, state_nxt;
  op_t              op;
  logic [WIDTH-1:0] tx, ty;
  logic [DW-1:0]    div_cnt;
  logic             run_q;
  logic             accept, point_end, done;
  logic             ld, stp, mv;

  // run_q keeps ready low during reset and raises it on the first edge after release
  assign bus.ready   = (state == IDLE) && run_q;
  assign bus.beam_on = (state == DRAW);
  assign accept      = bus.ready && (bus.draw || bus.jump);
  assign point_end   = (div_cnt == DW'(STEP_DIV - 1));

  line_stepper #(.WIDTH(WIDTH)) u_stepper (
    .clk   (clk),
    .reset (reset),
    .load  (ld),
    .step  (stp),
    .move  (mv),
    .tx    (tx),
    .ty    (ty),
    .x_pos (bus.x_out),
    .y_pos (bus.y_out),
    .done  (done)
  );

  // Next state and stepper strobes
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    stp       = 1'b0;
    mv        = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = SETUP;
      SETUP: begin
        if (op == OP_JUMP) begin
          mv        = 1'b1;
          state_nxt = JUMP_DWELL ? SETTLE : IDLE;
        end else begin
          ld        = 1'b1;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (point_end) begin
          if (done) state_nxt = IDLE;
          else      stp       = 1'b1;
        end
      end
`ifdef BEAM_JUMP_SETTLE_EN
      SETTLE: if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State, ready arming, command latch and per-point hold counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      run_q   <= 1'b0;
      op      <= OP_JUMP;
      tx      <= '0;
      ty      <= '0;
      div_cnt <= '0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
      if (accept) begin
        tx <= bus.x;
        ty <= bus.y;
        op <= bus.jump ? OP_JUMP : OP_DRAW;
      end
      if (state != DRAW || point_end) div_cnt <= '0;
      else                            div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef BEAM_JUMP_SETTLE_EN
  // Blanked dwell counter after a jump
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               settle_cnt <= '0;
    else if (state != SETTLE) settle_cnt <= '0;
    else                      settle_cnt <= settle_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_beam_line_engine.sv
// Directed bench for beam_line_engine: table of commands plus trace and reset-abort sequences.
// Two instances: STEP_DIV=1 and STEP_DIV=2, both SETTLE_CYCLES=4 (dwell only with BEAM_JUMP_SETTLE_EN).
// Expected latencies and points are hand-computed Bresenham results.
module tb_beam_line_engine;
  localparam int W     = 12;
  localparam int LIMIT = 5000;
`ifdef BEAM_JUMP_SETTLE_EN
  localparam int JL = 1 + 4;
`else
  localparam int JL = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sel = 1'b0;
  logic [W-1:0] cmd_x = '0, cmd_y = '0;
  logic cmd_draw = 1'b0, cmd_jump = 1'b0;
  logic r_ready, r_beam;
  logic [W-1:0] r_x, r_y;

  int n_chk = 0;
  int n_fail = 0;
  logic [2*W-1:0] trace_q[$];

  always #5 clk = ~clk;

  beam_line_engine_if #(.WIDTH(W)) bif1();
  beam_line_engine_if #(.WIDTH(W)) bif2();

  assign bif1.x = cmd_x;
  assign bif1.y = cmd_y;
  assign bif2.x = cmd_x;
  assign bif2.y = cmd_y;
  assign bif1.draw = cmd_draw & ~sel;
  assign bif1.jump = cmd_jump & ~sel;
  assign bif2.draw = cmd_draw & sel;
  assign bif2.jump = cmd_jump & sel;

  assign r_ready = sel ? bif2.ready   : bif1.ready;
  assign r_beam  = sel ? bif2.beam_on : bif1.beam_on;
  assign r_x     = sel ? bif2.x_out   : bif1.x_out;
  assign r_y     = sel ? bif2.y_out   : bif1.y_out;

  beam_line_engine #(.WIDTH(W), .STEP_DIV(1), .SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bif1.slave));
  beam_line_engine #(.WIDTH(W), .STEP_DIV(2), .SETTLE_CYCLES(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bif2.slave));

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one command to the selected DUT; report edges-to-ready and beam-on clocks
  task automatic run_cmd(input bit d, input bit j, input int cx, input int cy,
                         output int lat, output int beams);
    lat   = -1;
    beams = 0;
    trace_q.delete();
    for (int k = 0; k < 20 && !r_ready; k++) @(negedge clk);
    @(negedge clk);
    cmd_x    = W'(cx);
    cmd_y    = W'(cy);
    cmd_draw = d;
    cmd_jump = j;
    @(posedge clk);
    #1;
    cmd_draw = 1'b0;
    cmd_jump = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk);
      #1;
      if (r_beam) begin
        beams++;
        trace_q.push_back({r_x, r_y});
      end
      if (r_ready) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    bit d;
    bit j;
    int cx;
    int cy;
    int lat;
    int beams;
    int ex;
    int ey;
  } vec_t;

  vec_t tbl[9];
  int   lat, beams;
  int   exp_pts[$];

  initial begin
    tbl[0] = '{1'b0, 1'b1,  100, 200,   JL,    0,  100, 200};  // jump
    tbl[1] = '{1'b1, 1'b0,  100, 200,    2,    1,  100, 200};  // zero-length dot
    tbl[2] = '{1'b1, 1'b0,   97, 204,    6,    5,   97, 204};  // steep, x decreasing
    tbl[3] = '{1'b1, 1'b1, 4095,   0,   JL,    0, 4095,   0};  // draw+jump -> jump
    tbl[4] = '{1'b1, 1'b0, 4095,   3,    5,    4, 4095,   3};  // vertical at x max
    tbl[5] = '{1'b1, 1'b0,    0,   3, 4097, 4096,    0,   3};  // full-width horizontal
    tbl[6] = '{1'b0, 1'b1,    0,   0,   JL,    0,    0,   0};  // jump home
    tbl[7] = '{1'b1, 1'b0,    5,   2,    7,    6,    5,   2};  // shallow line
    tbl[8] = '{1'b1, 1'b0,    5,   2,    2,    1,    5,   2};  // dot at current pos

    // Reset held for 3 clocks: ready must stay low
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("rst_ready1", int'(bif1.ready), 0);
      check("rst_ready2", int'(bif2.ready), 0);
    end
    check("rst_x", int'(bif1.x_out), 0);
    check("rst_y", int'(bif1.y_out), 0);
    check("rst_beam", int'(bif1.beam_on), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready1", int'(bif1.ready), 1);
    check("rel_ready2", int'(bif2.ready), 1);
    check("rel_x", int'(bif1.x_out), 0);
    check("rel_beam", int'(bif1.beam_on), 0);

    // Table-driven commands on the STEP_DIV=1 instance
    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].d, tbl[i].j, tbl[i].cx, tbl[i].cy, lat, beams);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d_beam_clocks", i), beams, tbl[i].beams);
      check($sformatf("vec%0d_x", i), int'(r_x), tbl[i].ex);
      check($sformatf("vec%0d_y", i), int'(r_y), tbl[i].ey);
    end

    // Point trace (0,0)->(5,2), STEP_DIV=1
    run_cmd(1'b0, 1'b1, 0, 0, lat, beams);
    run_cmd(1'b1, 1'b0, 5, 2, lat, beams);
    check("trace1_latency", lat, 7);
    exp_pts = '{0, 0, 1, 0, 2, 1, 3, 1, 4, 2, 5, 2};
    check("trace1_len", trace_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("trace1_pt%0d", i),
            (i < trace_q.size()) ? int'(trace_q[i]) : -1,
            (exp_pts[2*i] << W) | exp_pts[2*i+1]);

    // Point trace (10,10)->(7,14) on the STEP_DIV=2 instance: each point held 2 clocks
    sel = 1'b1;
    run_cmd(1'b0, 1'b1, 10, 10, lat, beams);
    check("div2_jump_latency", lat, JL);
    run_cmd(1'b1, 1'b0, 7, 14, lat, beams);
    check("div2_latency", lat, 11);
    check("div2_beam_clocks", beams, 10);
    check("div2_final_x", int'(r_x), 7);
    check("div2_final_y", int'(r_y), 14);
    exp_pts = '{10, 10, 9, 11, 8, 12, 8, 13, 7, 14};
    for (int i = 0; i < 10; i++)
      check($sformatf("div2_pt%0d", i),
            (i < trace_q.size()) ? int'(trace_q[i]) : -1,
            (exp_pts[2*(i/2)] << W) | exp_pts[2*(i/2)+1]);
    sel = 1'b0;

    // Reset in the middle of a long diagonal draw aborts it at once
    run_cmd(1'b0, 1'b1, 0, 0, lat, beams);
    @(negedge clk);
    cmd_x    = W'(4095);
    cmd_y    = W'(4095);
    cmd_draw = 1'b1;
    @(posedge clk);
    #1;
    cmd_draw = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("diag_beam", int'(bif1.beam_on), 1);
    check("diag_x", int'(bif1.x_out), 19);
    check("diag_y", int'(bif1.y_out), 19);
    #1;
    reset = 1'b0;
    #1;
    check("abort_beam", int'(bif1.beam_on), 0);
    check("abort_x", int'(bif1.x_out), 0);
    check("abort_y", int'(bif1.y_out), 0);
    check("abort_ready", int'(bif1.ready), 0);
    @(posedge clk);
    #1;
    check("abort_ready_held", int'(bif1.ready), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready_rel", int'(bif1.ready), 1);
    check("abort_beam_rel", int'(bif1.beam_on), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
